// File: rtl/rv_ex_pkg.sv
// Shared execute-stage definitions: ALU and M-extension opcodes plus the
// execute-stage sequencer state type.
package rv_ex_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_PASS = 5'd10;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ex_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide core: works on operand magnitudes in a
// shared 2*XLEN accumulator and applies the RISC-V sign fix-up on the way out.
module muldiv_iter
    import rv_ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   mag_b_r;
    logic [2:0]        op_r;
    logic              neg_r;
    logic              special_r;
    logic [CW-1:0]     cnt_r;

    logic              a_signed_s, b_signed_s, sign_a_s, sign_b_s, neg_s;
    logic              div_zero_s, overflow_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_val_s;
    logic [XLEN:0]     sum_s, trial_s;
    logic              geq_s;
    logic [XLEN-1:0]   rem_next_s, quo_s, rem_s;
    logic [2*XLEN-1:0] acc_next_s, prod_s;

    // Operand signedness, magnitudes, result sign and special-case detection
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op)
            MD_MULH, MD_DIV, MD_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            MD_MULHSU: a_signed_s = 1'b1;
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sign_a_s   = a_signed_s & src_a[XLEN-1];
        sign_b_s   = b_signed_s & src_b[XLEN-1];
        mag_a_s    = sign_a_s ? (ZERO - src_a) : src_a;
        mag_b_s    = sign_b_s ? (ZERO - src_b) : src_b;
        neg_s      = (op == MD_REM) ? sign_a_s : (sign_a_s ^ sign_b_s);
        div_zero_s = op[2] & (src_b == ZERO);
        overflow_s = ((op == MD_DIV) | (op == MD_REM)) & (src_a == INT_MIN) & (src_b == ALL_ONES);
        if (div_zero_s) begin
            special_val_s = op[1] ? src_a : ALL_ONES;
        end else begin
            special_val_s = op[1] ? ZERO : src_a;
        end
    end

    assign special = div_zero_s | overflow_s;
    assign last    = (cnt_r == CW'(XLEN - 1));

    // One shift-add multiply or restoring-divide step; the divide keeps the
    // partial remainder in the upper half and shifts quotient bits into the lower
    always_comb begin
        sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, mag_b_r};
        trial_s    = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        geq_s      = (trial_s >= {1'b0, mag_b_r});
        rem_next_s = trial_s[XLEN-1:0] - mag_b_r;
        if (op_r[2]) begin
            if (geq_s) begin
                acc_next_s = {rem_next_s, acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else if (acc_r[0]) begin
            acc_next_s = {sum_s, acc_r[XLEN-1:1]};
        end else begin
            acc_next_s = {1'b0, acc_r[2*XLEN-1:1]};
        end
    end

    // Sign fix-up and half selection for the finished operation
    always_comb begin
        prod_s = neg_r ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
        quo_s  = neg_r ? (ZERO - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        rem_s  = neg_r ? (ZERO - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
        if (special_r) begin
            result = acc_r[XLEN-1:0];
        end else if (!op_r[2]) begin
            result = (op_r == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (op_r[1]) begin
            result = rem_s;
        end else begin
            result = quo_s;
        end
    end

    // Operand capture on start, then one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {(2*XLEN){1'b0}};
            mag_b_r   <= ZERO;
            op_r      <= 3'd0;
            neg_r     <= 1'b0;
            special_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else if (start) begin
            op_r      <= op;
            neg_r     <= neg_s;
            special_r <= special;
            mag_b_r   <= mag_b_s;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= special ? {ZERO, special_val_s} : {ZERO, mag_a_s};
        end else if (step) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU/link path plus an iterative M-extension
// unit that holds the pipeline via stall until its result is issued.
module ex_muldiv_stage
    import rv_ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int MD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] reg0,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            alu_src0,
    input  logic            alu_src1,
    input  logic [4:0]      alu_op,
    input  logic            jal_or_jalr,
    input  logic            forward_sel0,
    input  logic            forward_sel1,
    input  logic [XLEN-1:0] forward_reg0,
    input  logic [XLEN-1:0] forward_reg1,
    input  logic            is_md,
    input  logic [2:0]      md_op,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] res,
    output logic [XLEN-1:0] reg1_out
);

    localparam int   SHW   = $clog2(XLEN);
    localparam logic MD_ON = (MD_EN != 0);

    ex_state_t       state_r;
    logic [XLEN-1:0] src0_s, src1_s, md_result_s;
    logic            accept_s, step_s, md_special_s, md_last_s;

    function automatic logic [XLEN-1:0] alu_fn(input logic [4:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[SHW-1:0];
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[SHW-1:0];
            ALU_SRA:  r = $signed(a) >>> b[SHW-1:0];
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_PASS: r = b;
            default:  r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    assign src0_s   = alu_src0 ? pc : (forward_sel0 ? forward_reg0 : reg0);
    assign src1_s   = alu_src1 ? imm : (forward_sel1 ? forward_reg1 : reg1);
    assign reg1_out = forward_sel1 ? forward_reg1 : reg1;
    assign accept_s = (state_r == IDLE) & in_valid & is_md & MD_ON & !flush;
    assign step_s   = (state_r == RUN) & !flush;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s),
        .step    (step_s),
        .op      (md_op),
        .src_a   (src0_s),
        .src_b   (src1_s),
        .special (md_special_s),
        .last    (md_last_s),
        .result  (md_result_s)
    );

    // Sequencer: special cases skip straight to DONE; flush aborts at any point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= md_special_s ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_r <= IDLE;
                    end else if (md_last_s) begin
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Stage outputs; ALU results are same-cycle so these cannot be registered
    always_comb begin
        stall     = 1'b0;
        out_valid = 1'b0;
        res       = {XLEN{1'b0}};
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        stall = 1'b1;
                    end else if (in_valid & !(is_md & MD_ON) & !flush) begin
                        out_valid = 1'b1;
                        res       = jal_or_jalr ? (pc + {{(XLEN-3){1'b0}}, 3'd4})
                                                : alu_fn(alu_op, src0_s, src1_s);
                    end else begin
                        stall = 1'b0;
                    end
                end
                RUN:  stall = !flush;
                DONE: begin
                    if (!flush) begin
                        out_valid = 1'b1;
                        res       = md_result_s;
                    end else begin
                        out_valid = 1'b0;
                    end
                end
                default: stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage: a per-cycle checker compares every output
// against expectations derived from a plain-arithmetic M-extension model.
module tb_ex_muldiv_stage;
    import rv_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, alu_src0, alu_src1, jal_or_jalr, forward_sel0, forward_sel1;
    logic        is_md, flush;
    logic [31:0] reg0, reg1, imm, pc, forward_reg0, forward_reg1;
    logic [4:0]  alu_op;
    logic [2:0]  md_op;
    logic        stall, out_valid;
    logic [31:0] res, reg1_out;

    logic        check_en = 1'b0;
    logic        exp_stall, exp_ov;
    logic [31:0] exp_res;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ex_muldiv_stage #(.XLEN(32), .MD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .reg0(reg0), .reg1(reg1),
        .imm(imm), .pc(pc), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
        .jal_or_jalr(jal_or_jalr), .forward_sel0(forward_sel0), .forward_sel1(forward_sel1),
        .forward_reg0(forward_reg0), .forward_reg1(forward_reg1), .is_md(is_md),
        .md_op(md_op), .flush(flush), .stall(stall), .out_valid(out_valid), .res(res),
        .reg1_out(reg1_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            check("res", res, exp_res);
            check("reg1_out", reg1_out, forward_sel1 ? forward_reg1 : reg1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; alu_src0 = 1'b0; alu_src1 = 1'b0; jal_or_jalr = 1'b0;
        forward_sel0 = 1'b0; forward_sel1 = 1'b0; is_md = 1'b0; flush = 1'b0;
        reg0 = 32'd0; reg1 = 32'd0; imm = 32'd0; pc = 32'd0;
        forward_reg0 = 32'd0; forward_reg1 = 32'd0; alu_op = ALU_ADD; md_op = MD_MUL;
    endtask

    task automatic set_exp(input logic s, input logic ov, input logic [31:0] r);
        exp_stall = s; exp_ov = ov; exp_res = r;
    endtask

    task automatic alu_cycle(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hand);
        next_cycle();
        set_idle();
        in_valid = 1'b1; alu_op = op; reg0 = a; reg1 = b;
        set_exp(1'b0, 1'b1, hand);
    endtask

    // Issue one M op; optionally via forward_reg0, which is disturbed at chg_cycle
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hand, input bit special, input bit use_fwd,
                          input int chg_cycle);
        int lat = special ? 1 : 33;
        next_cycle();
        set_idle();
        in_valid = 1'b1; is_md = 1'b1; md_op = op; reg1 = b;
        if (use_fwd) begin
            forward_sel0 = 1'b1; forward_reg0 = a; reg0 = 32'hDEAD_BEEF;
        end else begin
            reg0 = a;
        end
        set_exp(1'b1, 1'b0, 32'd0);
        for (int c = 1; c <= lat; c++) begin
            next_cycle();
            if (c == chg_cycle) forward_reg0 = a ^ 32'h1234_5678;
            if (c == lat) set_exp(1'b0, 1'b1, ref_md(op, a, b));
            else set_exp(1'b1, 1'b0, 32'd0);
        end
        @(negedge clk);
        #1;
        check("md_hand", res, hand);
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        in_valid = 1'b1; reg0 = 32'd5; reg1 = 32'd7; forward_sel1 = 1'b1; forward_reg1 = 32'd9;
        set_exp(1'b0, 1'b0, 32'd0);
        check_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        set_idle();
        set_exp(1'b0, 1'b0, 32'd0);

        alu_cycle(ALU_ADD, 32'd5, 32'd7, 32'd12);
        next_cycle();
        set_idle();
        in_valid = 1'b1; jal_or_jalr = 1'b1; pc = 32'h100;
        set_exp(1'b0, 1'b1, 32'h104);
        alu_cycle(ALU_SUB, 32'd10, 32'd0, 32'd7);
        forward_sel1 = 1'b1; forward_reg1 = 32'd3;
        alu_cycle(ALU_ADD, 32'd0, 32'd0, 32'h1020);
        alu_src0 = 1'b1; alu_src1 = 1'b1; pc = 32'h1000; imm = 32'h20;
        alu_cycle(ALU_ADD, 32'd1, 32'd1, 32'd0);
        flush = 1'b1; set_exp(1'b0, 1'b0, 32'd0);
        next_cycle();
        set_idle();
        in_valid = 1'b1; is_md = 1'b1; md_op = MD_DIVU; reg0 = 32'd100; reg1 = 32'd7; flush = 1'b1;
        set_exp(1'b0, 1'b0, 32'd0);
        next_cycle();
        set_idle();
        set_exp(1'b0, 1'b0, 32'd0);

        run_md(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 0);
        run_md(MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 0);
        run_md(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 0);
        run_md(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_md(MD_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 0);
        run_md(MD_MULHSU, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_md(MD_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        run_md(MD_REM,    32'd100,       32'd0,         32'd100,       1'b1, 1'b0, 0);
        run_md(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 0);
        run_md(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0, 0);
        run_md(MD_MULHU,  32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0, 1'b1, 5);

        next_cycle();
        set_idle();
        in_valid = 1'b1; is_md = 1'b1; md_op = MD_DIVU; reg0 = 32'd100; reg1 = 32'd7;
        set_exp(1'b1, 1'b0, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c == 10) begin
                flush = 1'b1;
                set_exp(1'b0, 1'b0, 32'd0);
            end else begin
                set_exp(1'b1, 1'b0, 32'd0);
            end
        end
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            set_idle();
            set_exp(1'b0, 1'b0, 32'd0);
        end
        alu_cycle(ALU_ADD, 32'd1, 32'd2, 32'd3);

        next_cycle();
        set_idle();
        in_valid = 1'b1; is_md = 1'b1; md_op = MD_MUL; reg0 = 32'd6; reg1 = 32'd7;
        set_exp(1'b1, 1'b0, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            set_exp(1'b1, 1'b0, 32'd0);
        end
        next_cycle();
        rst_n = 1'b0;
        set_exp(1'b0, 1'b0, 32'd0);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        set_idle();
        set_exp(1'b0, 1'b0, 32'd0);
        for (int c = 0; c < 40; c++) begin
            next_cycle();
        end
        run_md(MD_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 0);

        next_cycle();
        set_idle();
        set_exp(1'b0, 1'b0, 32'd0);
        next_cycle();
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_stage.md
# ex_muldiv_stage

Parametrised execute stage for the RV32I/RV32IM pipeline. It keeps the single-cycle ALU/forwarding/link-address path and adds an iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). The M-extension unit holds the pipeline through a stall output until its result is ready. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
- XLEN, 32: datapath width.
- MD_EN, 1: 1 = M-extension present; 0 = `is_md` is ignored and the ALU path handles the instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID/EX holds a valid instruction.
- reg0, reg1  in  XLEN  register-file operands.
- imm, pc  in  XLEN  immediate and instruction PC.
- alu_src0  in  1  1 selects pc as operand 0 (auipc).
- alu_src1  in  1  1 selects imm as operand 1.
- alu_op  in  5  ALU operation code (shared package encoding).
- jal_or_jalr  in  1  result = pc + 4.
- forward_sel0, forward_sel1  in  1  select the forwarded operand.
- forward_reg0, forward_reg1  in  XLEN  forwarded values.
- is_md  in  1  the instruction is an M-extension op.
- md_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- flush  in  1  kill the instruction in EX (branch redirect).
- stall  out  1  hold the PC, IF/ID and ID/EX registers.
- out_valid  out  1  `res` is valid for EX/MEM this cycle.
- res  out  XLEN  stage result.
- reg1_out  out  XLEN  forwarded reg1, used as store data.

## Operation
- Operand selection:
  - src0 = alu_src0 ? pc : (forward_sel0 ? forward_reg0 : reg0).
  - src1 = alu_src1 ? imm : (forward_sel1 ? forward_reg1 : reg1).
  - reg1_out = forward_sel1 ? forward_reg1 : reg1.
  - reg1_out is combinational in every state.
- Non-M path, state IDLE with in_valid & !is_md:
  - res = jal_or_jalr ? pc+4 (mod 2^XLEN) : alu(src0, src1).
  - out_valid = !flush; stall = 0.
- FSM states are IDLE, RUN, DONE.
- IDLE → RUN: in_valid & is_md & MD_EN & !flush.
  - Capture src0, src1, md_op, signs and magnitudes into the sub-module.
  - stall = 1; counter = 0.
  - Captured operands are immune to later input or forward changes.
- IDLE → DONE directly (special cases, no iteration):
  - Divisor == 0: DIV/DIVU quotient = all ones; REM/REMU remainder = dividend.
  - Signed overflow, DIV/REM with dividend = 2^(XLEN-1) and divisor = −1: quotient = dividend, remainder = 0.
  - stall = 1 in the accept cycle.
- RUN:
  - One radix-2 step per cycle: shift-add multiply on magnitudes into a 2·XLEN product, or restoring divide on magnitudes.
  - counter increments each cycle; after the step with counter = XLEN−1, go to DONE.
  - stall = 1.
- DONE:
  - Apply sign correction:
    - Product is negated if the signs differ (MULH: both signed; MULHSU: rs1 signed only; MULHU/MUL: unsigned magnitudes).
    - Quotient takes sign(a) XOR sign(b); remainder takes sign(a).
  - MUL returns the low half; MULH* return the high half.
  - res = corrected result, out_valid = 1, stall = 0; return to IDLE.
  - In DONE the held instruction is still on the inputs and is consumed, never restarted.
- Flush:
  - flush in RUN or DONE → IDLE next edge; out_valid = 0, stall = 0 that cycle; no result is issued.
  - flush in IDLE suppresses out_valid and prevents acceptance.
- res = 0 whenever out_valid = 0.

## Timing
- Reset (async): state IDLE, counter 0, result and operand registers 0.
  - While rst_n is low: stall = 0, out_valid = 0, res = 0; reg1_out stays combinational.
- ALU ops: 0-cycle latency, combinational from inputs.
- M ops, normal case: accept at cycle 0, RUN in cycles 1..XLEN, DONE at cycle XLEN+1.
  - stall is high in cycles 0..XLEN (XLEN+1 cycles total).
  - out_valid pulses high for exactly one cycle, at cycle XLEN+1.
- M ops, special case: stall high in cycle 0, out_valid high in cycle 1.
- Back-to-back M ops: the second one is accepted in the cycle after DONE.
- Reset asserted mid-operation aborts immediately; nothing is issued after release.
- counter width is clog2(XLEN)+1.

## Structure
- Shared package `rv_ex_pkg`:
  - alu_op constants.
  - md_op constants.
  - ex_state_t enum {IDLE, RUN, DONE}.
- One sub-module, `muldiv_iter`, contains the operand/accumulator registers, counter, step datapath and sign fix-up. It exposes start, done, result and special-case detection.
- The ALU is reused unchanged.

## Test plan
- ADD with reg0=5, reg1=7, in_valid → same-cycle res=12, out_valid=1, stall=0; JAL with pc=0x100 → res=0x104.
- MULH 0x80000000×0x80000000 → stall high 33 cycles, then one out_valid cycle with res=0x40000000; MUL 0xFFFFFFFF×0xFFFFFFFF → res=1.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14, latency 33.
- DIVU 100/0 → 0xFFFFFFFF and REM 100/0 → 100; DIV 0x80000000/−1 → 0x80000000 and REM → 0; each with 1 stall cycle and out_valid in the next cycle.
- Change forward_reg0 at cycle 5 of a MULHU → result still uses the captured operand.
- Flush at RUN cycle 10 → stall=0 next cycle, no out_valid, following ADD completes normally; rst_n low mid-RUN → stall=0, out_valid=0 immediately.
